freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 14 +
 rtl/freq_meter_bin2bcd_seq.sv | 49 ++++
 rtl/freq_meter.sv | 94 +++++++++
 tb/tb_freq_meter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared BCD geometry, control FSM encoding and the double-dabble digit adjust.
package freq_meter_pkg;
    localparam int BCD_DIGITS = 8;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    typedef enum logic {COUNT = 1'b0, CONV = 1'b1} state_e;

    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        for (int i = 0; i < BCD_DIGITS; i++)
            r[4*i +: 4] = (b[4*i +: 4] > 4'd4) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        return r;
    endfunction
endpackage

// File: rtl/freq_meter_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one bit per cycle; the start cycle already performs the first shift,
// so done_o rises exactly W cycles after start_i and the result then holds in bcd_o.
module bin2bcd_seq
    import freq_meter_pkg::*;
#(
    parameter int W = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [W-1:0]     bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]     sh_q;
    logic [BCD_W-1:0] bcd_q, adj;
    logic [CW-1:0]    cnt_q;
    logic             done_q;

    assign adj = dabble_adj(bcd_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                bcd_q <= {{(BCD_W-1){1'b0}}, bin_i[W-1]};
                sh_q  <= bin_i << 1;
                cnt_q <= CW'(W - 1);
            end else if (cnt_q != '0) begin
                bcd_q  <= {adj[BCD_W-2:0], sh_q[W-1]};
                sh_q   <= sh_q << 1;
                cnt_q  <= cnt_q - 1'b1;
                done_q <= cnt_q == CW'(1);
            end
        end
    end

    assign busy_o = cnt_q != '0;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts synchronized rising edges of sig_in over GATE_CYCLES-cycle windows.
// FREQ_METER_BCD_EN adds a sequential BCD readout of each result; otherwise bcd_out is tied to 0.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter logic [31:0] GATE_CYCLES = 32'd27000000,
    parameter int          CNT_W       = 24
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_hz,
    output logic             ovf,
    output logic [BCD_W-1:0] bcd_out,
    output logic             valid
);
    logic             s1_q, s2_q, s3_q, edge_w, last_w, sat_now;
    logic [31:0]      gcnt_q;
    logic [CNT_W-1:0] ecnt_q, freq_q, total_d;
    logic             sat_q, ovf_q, ovf_d, valid_q;

    // An edge in the closing cycle still belongs to the closing window.
    always_comb begin
        edge_w  = s2_q & ~s3_q;
        last_w  = gcnt_q == GATE_CYCLES - 32'd1;
        sat_now = edge_w & (&ecnt_q);
        total_d = ecnt_q + CNT_W'(edge_w & ~sat_now);
        ovf_d   = sat_q | sat_now;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            {s1_q, s2_q, s3_q} <= 3'b000;
            gcnt_q <= '0;
            ecnt_q <= '0;
            sat_q  <= 1'b0;
            freq_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            {s1_q, s2_q, s3_q} <= {sig_in, s1_q, s2_q};
            gcnt_q <= last_w ? '0 : gcnt_q + 32'd1;
            ecnt_q <= last_w ? '0 : total_d;
            sat_q  <= last_w ? 1'b0 : ovf_d;
            if (last_w) begin
                freq_q <= total_d;
                ovf_q  <= ovf_d;
            end
        end
    end

`ifdef FREQ_METER_BCD_EN
    state_e           state_q;
    logic [BCD_W-1:0] bcd_q, b2b_bcd;
    logic             b2b_busy, b2b_done;

    bin2bcd_seq #(.W(CNT_W)) u_b2b (
        .clk_i  (clk_in),
        .rst_i  (rst),
        .start_i(last_w),
        .bin_i  (total_d),
        .busy_o (b2b_busy),
        .done_o (b2b_done),
        .bcd_o  (b2b_bcd)
    );

    // A latch during CONV restarts the converter and stays in CONV.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= COUNT;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (last_w)
                state_q <= CONV;
            else if (state_q == CONV && !b2b_busy) begin
                state_q <= COUNT;
                bcd_q   <= b2b_bcd;
                valid_q <= b2b_done;
            end
        end
    end

    assign bcd_out = bcd_q;
`else
    always_ff @(posedge clk_in) valid_q <= !rst && last_w;

    assign bcd_out = '0;
`endif

    assign freq_hz = freq_q;
    assign ovf     = ovf_q;
    assign valid   = valid_q;
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench driving one sig_in into a CNT_W=24 and a CNT_W=4 meter (GATE_CYCLES=100).
module tb_freq_meter;
    import freq_meter_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, sig_in = 1'b0;
    logic [23:0] freq_a;
    logic [3:0]  freq_b;
    logic        ovf_a, ovf_b, valid_a, valid_b;
    logic [31:0] bcd_a, bcd_b;

`ifdef FREQ_METER_BCD_EN
    localparam bit BCD_ON = 1'b1;
`else
    localparam bit BCD_ON = 1'b0;
`endif
    localparam int LAT_A = BCD_ON ? 24 : 0;
    localparam int LAT_B = BCD_ON ? 4 : 0;

    typedef struct {int f; int o; logic [31:0] b; int t;} exp_t;
    exp_t qa[$], qb[$];

    int gc = 0, g0 = 0, checks = 0, failures = 0;

    int          e1_f[9] = '{10, 10, 10, 0, 1, 0, 1, 0, 1};
    logic [31:0] e1_b[9] = '{32'h10, 32'h10, 32'h10, 32'h0, 32'h1, 32'h0, 32'h1, 32'h0, 32'h1};
    int          e2_fa[3] = '{3, 50, 10};
    int          e2_fb[3] = '{3, 15, 10};
    int          e2_ob[3] = '{0, 1, 0};
    logic [31:0] e2_ba[3] = '{32'h3, 32'h50, 32'h10};
    logic [31:0] e2_bb[3] = '{32'h3, 32'h15, 32'h10};

    freq_meter #(.GATE_CYCLES(100), .CNT_W(24)) dut_a (
        .clk_in(clk), .rst(rst), .sig_in(sig_in),
        .freq_hz(freq_a), .ovf(ovf_a), .bcd_out(bcd_a), .valid(valid_a)
    );
    freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut_b (
        .clk_in(clk), .rst(rst), .sig_in(sig_in),
        .freq_hz(freq_b), .ovf(ovf_b), .bcd_out(bcd_b), .valid(valid_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) gc <= gc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=valid required=no_pending_result", name);
    endtask

    // Monitors: each valid pulse pops one expected window result, including the cycle it must appear in.
    always @(negedge clk) begin
        if (valid_a === 1'b1) begin
            if (qa.size() == 0) unexpected("a_valid");
            else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_freq", 32'(freq_a), e.f);
                chk("a_ovf", 32'(ovf_a), e.o);
                chk("a_bcd", bcd_a, e.b);
                chk("a_valid_cycle", gc, e.t);
            end
        end
        if (valid_b === 1'b1) begin
            if (qb.size() == 0) unexpected("b_valid");
            else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_freq", 32'(freq_b), e.f);
                chk("b_ovf", 32'(ovf_b), e.o);
                chk("b_bcd", bcd_b, e.b);
                chk("b_valid_cycle", gc, e.t);
            end
        end
    end

    // sig_in value driven just after window cycle n of a segment (n counted from reset release).
    function automatic logic sig_at(input int seg, input int n);
        if (seg == 1)
            return n < 300 ? (n % 10 < 5) : n < 400 ? 1'b0 : n < 600 ? 1'b1 :
                   n < 900 ? (n == 697 || n == 798) : (n % 10 < 5);
        return n < 25 ? (n % 10 < 5) : (n >= 98 && n < 198) ? ~n[0] :
               (n >= 200 && n < 300) ? (n % 10 < 5) : 1'b0;
    endfunction

    task automatic push(input int seg, input int k);
        int t;
        t = g0 + 100 * (k + 1);
        if (seg == 1) begin
            qa.push_back('{e1_f[k], 0, BCD_ON ? e1_b[k] : 32'h0, t + LAT_A});
            qb.push_back('{e1_f[k], 0, BCD_ON ? e1_b[k] : 32'h0, t + LAT_B});
        end else begin
            qa.push_back('{e2_fa[k], 0, BCD_ON ? e2_ba[k] : 32'h0, t + LAT_A});
            qb.push_back('{e2_fb[k], e2_ob[k], BCD_ON ? e2_bb[k] : 32'h0, t + LAT_B});
        end
    endtask

    task automatic run_seg(input int seg, input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            if (n % 100 == 0 && n / 100 < (seg == 1 ? 9 : 3)) push(seg, n / 100);
            sig_in = sig_at(seg, n);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        g0 = gc;
        chk("rst_freq_a", 32'(freq_a), 0);
        chk("rst_ovf_a", 32'(ovf_a), 0);
        chk("rst_bcd_a", bcd_a, 0);
        chk("rst_valid_a", 32'(valid_a), 0);
        chk("rst_freq_b", 32'(freq_b), 0);
        chk("rst_ovf_b", 32'(ovf_b), 0);
        rst = 1'b0;
    endtask

    initial begin
        do_reset(3);
        run_seg(1, 950);
        do_reset(1);
        run_seg(2, 340);
        chk("a_results_outstanding", qa.size(), 0);
        chk("b_results_outstanding", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
